// File: rtl/pingpong_bank_reader.sv
// Read side of a two-bank ping-pong buffer.
// Captures completed banks from the writer, drains them in completion order
// (strictly alternating 0,1,0,...) through a 1-cycle-latency RAM read port,
// and presents the words as a valid/ready stream with end-of-bank marking.
//
// Ports:
//   clk, reset (async, active-low)
//   bank_done/bank_sel/bank_len : writer reports a completed bank and its fill count
//   bank_full[1:0], wr_stall    : per-bank full flags; stall when both are full
//   bank_free                   : 1-cycle pulse when a bank has been fully drained
//   rd_en/rd_bank/rd_addr       : RAM read request; rd_data returns one cycle later
//   out_valid/out_data/out_last : output beat, held while out_ready is low
//   out_ready                   : downstream accept
//   err                         : sticky protocol error (bad length or full-bank reuse)
module pingpong_bank_reader #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned LEN_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bank_done,
   input  logic              bank_sel,
   input  logic [LEN_W-1:0]  bank_len,
   output logic [1:0]        bank_full,
   output logic              wr_stall,
   output logic              bank_free,
   output logic              rd_en,
   output logic              rd_bank,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t            state;
   logic              nxt;
   logic [LEN_W-1:0]  len_q [2];
   logic              inflight;
   logic              inflight_last;
   logic [1:0]        fifo_count;
   logic [DATA_W-1:0] fifo_data1;
   logic              fifo_last1;

   logic              done_bad;
   logic              done_ok;
   logic              drain_done;
   logic              pop;
   logic              push;
   logic              rd_last;
   logic [ADDR_W-1:0] last_addr;
   logic [2:0]        occupancy;

   // Output FIFO: entry 0 is the head and drives out_data/out_last directly.
   assign out_valid = (fifo_count != 2'd0);
   assign wr_stall  = bank_full[0] & bank_full[1];

   // Capture qualification, read credit and drain-complete decode.
   always_comb begin
      done_bad   = bank_done & (bank_full[bank_sel] | (bank_len == '0) |
                                (bank_len > LEN_W'(DEPTH)));
      done_ok    = bank_done & ~done_bad;
      last_addr  = ADDR_W'(len_q[rd_bank] - LEN_W'(1));
      rd_last    = (rd_addr == last_addr);
      pop        = out_valid & out_ready;
      push       = inflight;
      occupancy  = 3'(fifo_count) + 3'(inflight);
      // A beat leaving this cycle frees a slot, which keeps 1 beat/cycle going.
      rd_en      = (state == READ) && (occupancy < (3'd2 + 3'(pop)));
      drain_done = (state == FLUSH) && (fifo_count == 2'd0) && !inflight;
   end

   // Bank bookkeeping, drain FSM and output FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         nxt           <= 1'b0;
         bank_full     <= 2'b00;
         len_q[0]      <= '0;
         len_q[1]      <= '0;
         err           <= 1'b0;
         bank_free     <= 1'b0;
         rd_bank       <= 1'b0;
         rd_addr       <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fifo_count    <= 2'd0;
         out_data      <= '0;
         out_last      <= 1'b0;
         fifo_data1    <= '0;
         fifo_last1    <= 1'b0;
      end else begin
         bank_free <= 1'b0;

         if (done_bad) err <= 1'b1;
         if (done_ok)  len_q[bank_sel] <= bank_len;

         // Clear of the drained bank and capture of the other may coincide.
         bank_full <= (bank_full & ~(drain_done ? (2'b01 << rd_bank) : 2'b00)) |
                      (done_ok ? (2'b01 << bank_sel) : 2'b00);

         case (state)
            IDLE: begin
               if (bank_full[nxt]) begin
                  state   <= READ;
                  rd_bank <= nxt;
                  rd_addr <= '0;
               end
            end
            READ: begin
               if (rd_en) begin
                  if (rd_last) state <= FLUSH;
                  else         rd_addr <= rd_addr + ADDR_W'(1);
               end
            end
            FLUSH: begin
               if (drain_done) begin
                  bank_free <= 1'b1;
                  nxt       <= ~nxt;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         inflight      <= rd_en;
         inflight_last <= rd_en & rd_last;

         case ({push, pop})
            2'b10: begin
               if (fifo_count == 2'd0) begin
                  out_data <= rd_data;
                  out_last <= inflight_last;
               end else begin
                  fifo_data1 <= rd_data;
                  fifo_last1 <= inflight_last;
               end
               fifo_count <= fifo_count + 2'd1;
            end
            2'b01: begin
               out_data   <= fifo_data1;
               out_last   <= fifo_last1 & (fifo_count == 2'd2);
               fifo_count <= fifo_count - 2'd1;
            end
            2'b11: begin
               if (fifo_count == 2'd1) begin
                  out_data <= rd_data;
                  out_last <= inflight_last;
               end else begin
                  out_data   <= fifo_data1;
                  out_last   <= fifo_last1;
                  fifo_data1 <= rd_data;
                  fifo_last1 <= inflight_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pingpong_bank_reader.sv
// Self-checking bench for pingpong_bank_reader: behavioural RAM, expected-beat
// scoreboard filled at bank completion, and an independent output monitor.
module tb_pingpong_bank_reader;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 9;
   localparam int unsigned LEN_W  = 10;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
      int                bank;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              bank_done = 1'b0;
   logic              bank_sel = 1'b0;
   logic [LEN_W-1:0]  bank_len = '0;
   logic [1:0]        bank_full;
   logic              wr_stall;
   logic              bank_free;
   logic              rd_en;
   logic              rd_bank;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data = '0;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready = 1'b0;
   logic              err;

   logic [DATA_W-1:0] mem [2][DEPTH];
   beat_t             exp_q [$];
   beat_t             e;
   bit                m_full [2];
   bit                m_err;
   int                m_frees = 0;
   int                frees_seen = 0;
   int                total = 0;
   int                bad = 0;
   int                issued = 0;
   int                accepted = 0;
   int                ready_mode = 0;
   bit                prev_hold = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic              prev_last;
   bit                wsel;

   always #5 clk = ~clk;

   pingpong_bank_reader #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .LEN_W (LEN_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bank_done(bank_done),
      .bank_sel (bank_sel),
      .bank_len (bank_len),
      .bank_full(bank_full),
      .wr_stall (wr_stall),
      .bank_free(bank_free),
      .rd_en    (rd_en),
      .rd_bank  (rd_bank),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_last (out_last),
      .out_ready(out_ready),
      .err      (err)
   );

   // 1-cycle-latency RAM read port
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_bank][rd_addr];

   // Downstream ready pattern: 0 = held by stimulus, 1 = toggle, 2 = random
   always @(posedge clk) begin
      #1;
      if (ready_mode == 1)      out_ready = ~out_ready;
      else if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each accepted beat
   always @(negedge clk) begin
      if (!reset) begin
         issued    = 0;
         accepted  = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", out_data, prev_data);
            check("hold_last", 64'(out_last), 64'(prev_last));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_beat: got data 0x%0h expected no beat", out_data);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", out_data, e.data);
               check("beat_last", 64'(out_last), 64'(e.last));
               if (e.last) begin
                  m_full[e.bank] = 1'b0;
                  m_frees++;
               end
            end
            accepted++;
         end
         if (rd_en) begin
            issued++;
            check("outstanding_le2", 64'((issued - accepted) <= 2), 64'(1));
         end
         if (bank_free) frees_seen++;
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_last = out_last;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      bank_done  = 1'b0;
      bank_sel   = 1'b0;
      bank_len   = '0;
      ready_mode = 0;
      out_ready  = 1'b0;
      #1;
      check("reset_outs", 64'({bank_full, wr_stall, bank_free, rd_en, rd_bank, rd_addr,
                               out_valid, out_last, err}), 64'(0));
      check("reset_data", out_data, 64'(0));
      exp_q.delete();
      m_full[0]  = 1'b0;
      m_full[1]  = 1'b0;
      m_err      = 1'b0;
      m_frees    = 0;
      frees_seen = 0;
      cyc(2);
      reset = 1'b1;
      cyc(1);
   endtask

   // Writer: fills the bank (if it may) and pulses bank_done for one cycle
   task automatic issue(input bit sel, input int len);
      beat_t b;
      if (len >= 1 && len <= int'(DEPTH) && !m_full[sel]) begin
         for (int i = 0; i < len; i++) begin
            mem[sel][i] = {$urandom, $urandom};
            b.data = mem[sel][i];
            b.last = (i == len - 1);
            b.bank = int'(sel);
            exp_q.push_back(b);
         end
         m_full[sel] = 1'b1;
      end else begin
         m_err = 1'b1;
      end
      bank_done = 1'b1;
      bank_sel  = sel;
      bank_len  = LEN_W'(len);
      cyc(1);
      bank_done = 1'b0;
   endtask

   task automatic wait_drained(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
         exp_q.delete();
      end
      cyc(3);
   endtask

   task automatic check_state(input string tag);
      check($sformatf("%s_bank_full", tag), 64'(bank_full), 64'({m_full[1], m_full[0]}));
      check($sformatf("%s_wr_stall", tag), 64'(wr_stall), 64'(m_full[0] & m_full[1]));
      check($sformatf("%s_err", tag), 64'(err), 64'(m_err));
      check($sformatf("%s_frees", tag), 64'(frees_seen), 64'(m_frees));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // 1: single bank, latency and back-to-back beats
      do_reset();
      out_ready = 1'b1;
      issue(1'b0, 4);
      check("t1_rd_en_c1", 64'(rd_en), 64'(0));
      cyc(1);
      check("t1_rd_en_c2", 64'(rd_en), 64'(1));
      check("t1_rd_addr", 64'(rd_addr), 64'(0));
      check("t1_rd_bank", 64'(rd_bank), 64'(0));
      n = 0;
      while (!out_valid && n < 20) begin cyc(1); n++; end
      for (int i = 0; i < 4; i++) begin
         check("t1_consec_valid", 64'(out_valid), 64'(1));
         cyc(1);
      end
      wait_drained(50);
      check_state("t1");

      // 2: both banks full under backpressure, then release
      do_reset();
      issue(1'b0, 3);
      issue(1'b1, 2);
      check_state("t2_stall");
      cyc(4);
      check("t2_stall_held", 64'(wr_stall), 64'(m_full[0] & m_full[1]));
      out_ready = 1'b1;
      n = 0;
      while (!bank_free && n < 50) begin cyc(1); n++; end
      check("t2_free_seen", 64'(bank_free), 64'(1));
      check("t2_stall_fall", 64'(wr_stall), 64'(m_full[0] & m_full[1]));
      check("t2_full_after_free", 64'(bank_full), 64'({m_full[1], m_full[0]}));
      wait_drained(50);
      check_state("t2");

      // 3: toggling ready
      do_reset();
      ready_mode = 1;
      issue(1'b0, 8);
      wait_drained(100);
      ready_mode = 0;
      check("t3_beats", 64'(accepted), 64'(8));
      check_state("t3");

      // 4: length boundaries
      do_reset();
      ready_mode = 2;
      issue(1'b0, 1);
      wait_drained(50);
      check_state("t4_len1");
      issue(1'b1, int'(DEPTH));
      wait_drained(4000);
      check_state("t4_depth");
      issue(1'b0, 0);
      check_state("t4_len0");
      do_reset();
      issue(1'b0, int'(DEPTH) + 1);
      check_state("t4_over");

      // 5: reuse of draining bank, then completion coinciding with the next bank_done
      do_reset();
      ready_mode = 2;
      issue(1'b0, 6);
      cyc(2);
      issue(1'b0, 2);
      check_state("t5_dup");
      n = 0;
      @(negedge clk);
      while (!(out_valid && out_ready && out_last) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t5_last_seen", 64'(out_valid && out_ready && out_last), 64'(1));
      @(posedge clk);
      #1;
      issue(1'b1, 5);
      check("t5_simul_full", 64'(bank_full), 64'({m_full[1], m_full[0]}));
      wait_drained(200);
      check_state("t5");

      // 6: reset mid-drain
      do_reset();
      out_ready = 1'b1;
      issue(1'b0, 6);
      cyc(4);
      do_reset();
      out_ready = 1'b1;
      issue(1'b0, 2);
      wait_drained(50);
      check("t6_beats", 64'(accepted), 64'(2));
      check_state("t6");

      // Random traffic: writer alternates banks and respects full flags
      do_reset();
      ready_mode = 2;
      wsel = 1'b0;
      for (int k = 0; k < 24; k++) begin
         n = 0;
         while (m_full[wsel] && n < 500) begin cyc(1); n++; end
         check("rnd_writer_wait", 64'(m_full[wsel]), 64'(0));
         cyc(2 + int'($urandom_range(0, 3)));
         issue(wsel, int'($urandom_range(1, 16)));
         wsel = ~wsel;
      end
      wait_drained(2000);
      ready_mode = 0;
      check_state("rnd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
